// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flop, LSB first, valid/ready on both sides.
// Optional subtract mode (sub port, a - b) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [WIDTH-1:0] sum_r;
  logic             c_r, carry_r;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             s_bit, c_nxt;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  // Subtract is a + ~b + 1, so only the captured b and the seed carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  assign s_bit = fa_sum(a_sr[0], b_sr[0], c_r);
  assign c_nxt = fa_carry(a_sr[0], b_sr[0], c_r);
  assign s_ext = {s_bit, s_sr};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      s_sr    <= '0;
      c_r     <= 1'b0;
      cnt     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sr <= a;
            b_sr <= b_cap;
            c_r  <= c_cap;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          c_r  <= c_nxt;
          s_sr <= s_ext[WIDTH:1];
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            sum_r   <= s_ext[WIDTH:1];
            carry_r <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = sum_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against
// an arithmetic reference model; subtract cases run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sv8, sr8, rv8, rr8, c8, cy8, busy8;
  logic [7:0] a8, b8, s8;
  logic       sv1, sr1, rv1, rr1, c1, cy1, busy1;
  logic [0:0] a1, b1, s1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .cin(c8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .res_valid(rv8), .res_ready(rr8), .sum(s8), .carry(cy8), .busy(busy8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(c1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(1'b0),
`endif
    .res_valid(rv1), .res_ready(rr1), .sum(s1), .carry(cy1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 transaction; hold=1 keeps res_ready low for 5 cycles and pokes start_valid.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input logic sb, input bit hold);
    logic [8:0] t;
    logic [7:0] es;
    logic       ec;
    int         j;
    int         bcnt;
    if (sb) begin
      es = av - bv;
      ec = (av >= bv);
    end else begin
      t  = {1'b0, av} + {1'b0, bv} + 9'(cv);
      es = t[7:0];
      ec = t[8];
    end
    rr8 = !hold;
    @(negedge clk);
    check("start_ready_idle", 64'(sr8), 64'(1));
    a8 = av; b8 = bv; c8 = cv; sv8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = sb;
`endif
    @(negedge clk);
    sv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 1'($urandom);
`endif
    j = 0; bcnt = 0;
    while (!rv8 && j < 20) begin
      bcnt += int'(busy8);
      @(negedge clk);
      j++;
    end
    check("latency8", 64'(j), 64'(8));
    check("busy_cycles8", 64'(bcnt), 64'(8));
    check("sum8", 64'(s8), 64'(es));
    check("carry8", 64'(cy8), 64'(ec));
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 1) begin
          sv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        end else begin
          sv8 = 1'b0;
        end
        @(negedge clk);
        check("hold_valid", 64'(rv8), 64'(1));
        check("hold_sum", 64'(s8), 64'(es));
        check("hold_carry", 64'(cy8), 64'(ec));
        check("hold_start_ready", 64'(sr8), 64'(0));
      end
      sv8 = 1'b0;
      rr8 = 1'b1;
      @(negedge clk);
      check("release_start_ready", 64'(sr8), 64'(1));
      check("release_busy", 64'(busy8), 64'(0));
      check("release_sum_kept", 64'(s8), 64'(es));
    end
    @(negedge clk);
    check("res_valid_drop", 64'(rv8), 64'(0));
    check("no_recapture", 64'(busy8), 64'(0));
  endtask

  task automatic run1(input logic av, input logic bv, input logic cv);
    logic [1:0] t;
    int         j;
    t = 2'(av) + 2'(bv) + 2'(cv);
    @(negedge clk);
    a1 = av; b1 = bv; c1 = cv; sv1 = 1'b1;
    @(negedge clk);
    sv1 = 1'b0; a1 = ~av; b1 = ~bv; c1 = ~cv;
    j = 0;
    while (!rv1 && j < 10) begin
      check("busy1", 64'(busy1), 64'(1));
      @(negedge clk);
      j++;
    end
    check("latency1", 64'(j), 64'(1));
    check("sum1", 64'(s1), 64'(t[0]));
    check("carry1", 64'(cy1), 64'(t[1]));
    @(negedge clk);
  endtask

  initial begin
    int rvcnt;
    sv8 = 0; rr8 = 1; a8 = 0; b8 = 0; c8 = 0;
    sv1 = 0; rr1 = 1; a1 = 0; b1 = 0; c1 = 0;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sum", 64'(s8), 64'(0));
    check("rst_carry", 64'(cy8), 64'(0));
    check("rst_res_valid", 64'(rv8), 64'(0));
    check("rst_busy", 64'(busy8), 64'(0));
    check("rst_start_ready", 64'(sr8), 64'(1));
    rst_n = 1'b1;

    run8(8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    run8(8'h5A, 8'hC3, 1'b1, 1'b0, 1'b1);

    // Reset lands on the third RUN cycle.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; c8 = 1'b0; sv8 = 1'b1;
    @(negedge clk);
    sv8 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", 64'(s8), 64'(0));
    check("midrst_carry", 64'(cy8), 64'(0));
    check("midrst_res_valid", 64'(rv8), 64'(0));
    check("midrst_busy", 64'(busy8), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rvcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rvcnt += int'(rv8);
    end
    check("midrst_no_result", 64'(rvcnt), 64'(0));
    run8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, (k % 7) == 3);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      run1(v[2], v[1], v[0]);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    run8(8'h07, 8'h05, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
